// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the IF/ID instruction queue.
// These mirror the defines.v constants used elsewhere in the pipeline:
// StallBus, InstAddrBus, InstBus, ZeroWord, Stop and NotStop.
// Optional feature macro used by the queue: IF_ID_QUEUE_BYPASS_EN.
package if_id_queue_pkg;

    // Pipeline stall vector width and the bit that holds the ID stage.
    localparam int STALL_BUS_W     = 6;
    localparam int STALL_ID_BIT    = 1;

    // Instruction address and instruction word widths.
    localparam int INST_ADDR_BUS_W = 32;
    localparam int INST_BUS_W      = 32;

    // All-zero word; an all-zero instruction is the pipeline NOP.
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Stall bit encodings.
    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    // One queue slot: the fetched PC together with its instruction word.
    typedef struct packed {
        logic [INST_ADDR_BUS_W-1:0] pc;
        logic [INST_BUS_W-1:0]      inst;
    } entry_t;

endpackage

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small circular FIFO of fetched instructions
// between the fetch and decode stages, with flush and ID-stall handling.
// Optional macro IF_ID_QUEUE_BYPASS_EN: when defined, an instruction
// pushed into an empty queue is presented to decode in the same cycle,
// and is not stored at all if decode consumes it in that cycle.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [STALL_BUS_W-1:0]     stall,
    input  logic                       flush_i,
    input  logic                       if_valid_i,
    input  logic [INST_ADDR_BUS_W-1:0] if_pc_i,
    input  logic [INST_BUS_W-1:0]      if_inst_i,
    output logic                       if_ready_o,
    output logic                       id_valid_o,
    output logic [INST_ADDR_BUS_W-1:0] id_pc_o,
    output logic [INST_BUS_W-1:0]      id_inst_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic   queue_valid;
    logic   id_hold;
    logic   push;
    logic   pop;
    logic   store;
    logic   deq;
    logic   bypass_hit;
    entry_t head;
    entry_t in_entry;

    // Only the ID-stage bit of the stall vector matters here.
    logic   unused_stall_bits;
    assign unused_stall_bits = ^{stall[STALL_BUS_W-1:STALL_ID_BIT+1], stall[STALL_ID_BIT-1:0]};

    // Readiness depends on occupancy alone, so a push into a full queue is
    // dropped even when decode frees a slot in the same cycle.
    assign if_ready_o  = (count != FULL_COUNT);
    assign queue_valid = (count != '0);
    assign id_hold     = (stall[STALL_ID_BIT] == STOP);
    assign push        = if_valid_i && if_ready_o && !flush_i;
    assign in_entry    = '{pc: if_pc_i, inst: if_inst_i};
    assign head        = mem[rd_ptr];
    assign count_o     = count;

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass_hit = push && !queue_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // Present the head entry (or the bypassed fetch) to decode; NOP when empty.
    always_comb begin
        id_valid_o = queue_valid || bypass_hit;
        id_pc_o    = ZERO_WORD;
        id_inst_o  = ZERO_WORD;
        if (bypass_hit) begin
            id_pc_o   = if_pc_i;
            id_inst_o = if_inst_i;
        end else if (queue_valid) begin
            id_pc_o   = head.pc;
            id_inst_o = head.inst;
        end
    end

    // A bypassed entry consumed in the same cycle never touches storage.
    assign pop   = id_valid_o && (stall[STALL_ID_BIT] == NOT_STOP) && !flush_i;
    assign store = push && !(bypass_hit && pop);
    assign deq   = pop && !bypass_hit;

    // Pointer and occupancy bookkeeping; reset beats flush, flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq && !id_hold) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({store, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (!rst && store) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule
